// File: rtl/psum_axis_tx_pkg.sv
// Shared constants, FSM encoding and the psum sign-extension helper for psum_axis_tx.
// Optional ReLU on the output path is enabled with `define PSUM_TX_RELU_EN.
package psum_tx_pkg;

  localparam int unsigned AXIS_W         = 32;
  localparam int unsigned PSUM_PACK_W    = 8;
  localparam int unsigned PSUMS_PER_BEAT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // raw holds a w-bit psum zero-extended to 8 bits; result is its 8-bit sign extension.
  function automatic logic [PSUM_PACK_W-1:0] sext_psum(input logic [PSUM_PACK_W-1:0] raw,
                                                       input int unsigned          w);
    logic [PSUM_PACK_W-1:0] res;
    logic [3:0]             sh;
    sh  = 4'(PSUM_PACK_W - w);
    res = raw << sh;
    res = $signed(res) >>> sh;
`ifdef PSUM_TX_RELU_EN
    if (res[PSUM_PACK_W-1]) res = '0;
`endif
    return res;
  endfunction

endpackage

// File: rtl/psum_axis_tx_if.sv
// AXI4-Stream link carrying packed psum beats toward the ofmaps DMA.
interface psum_axis_tx_if;
  import psum_tx_pkg::*;

  logic [AXIS_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/psum_axis_tx_vec_fifo.sv
// Synchronous vector FIFO; a write while full is accepted when a read frees the slot on the same edge.
module psum_vec_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 1280,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data_c,
  output logic             o_full_c,
  output logic             o_empty_c,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wr_drop_c
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full_c    = (r_count == CNT_W'(DEPTH));
  assign o_empty_c   = (r_count == '0);
  assign o_count     = r_count;
  assign o_rd_data_c = r_mem[r_rd_ptr];

  assign w_rd        = i_rd_en && !o_empty_c;
  assign w_wr        = i_wr_en && (!o_full_c || w_rd);
  assign o_wr_drop_c = i_wr_en && !w_wr;

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

  // Storage needs no reset; occupancy tracking guards every read
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/psum_axis_tx.sv
// Buffers psum vectors from the MAC array and serializes them onto an AXI4-Stream master with TLAST per frame.
// Define PSUM_TX_RELU_EN to zero negative psums on the output path.
module psum_axis_tx
  import psum_tx_pkg::*;
#(
  parameter int unsigned MAC_NUM         = 256,
  parameter int unsigned PSUM_W          = 5,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned FRAME_LEN_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PSUM_W*MAC_NUM-1:0]  psum_out,
  input  logic                       psum_valid,
  input  logic [FRAME_LEN_WIDTH-1:0] frame_len,
  output logic                       psum_almost_full,
  output logic                       overflow_err,
  output logic                       frame_done,
  psum_axis_tx_if.master             m_axis
);

  localparam int unsigned VEC_W   = PSUM_W * MAC_NUM;
  localparam int unsigned BEATS   = MAC_NUM / PSUMS_PER_BEAT;
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BEAT_SH = PSUM_W * PSUMS_PER_BEAT;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  tx_state_e                  r_state;
  tx_state_e                  w_state_nxt;
  logic [VEC_W-1:0]           r_shift;
  logic [BEAT_W-1:0]          r_beat_cnt;
  logic [FRAME_LEN_WIDTH-1:0] r_vec_cnt;
  logic [FRAME_LEN_WIDTH-1:0] r_frame_len_q;
  logic                       r_frame_done;
  logic                       r_overflow;

  logic [VEC_W-1:0]           w_fifo_rd_data;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [CNT_W-1:0]           w_fifo_count;
  logic                       w_wr_drop;
  logic                       w_hs;
  logic                       w_last_beat;
  logic                       w_last_vec;
  logic                       w_tlast;
  logic                       w_tvalid;
  logic                       w_pop;
  logic                       w_shift;
  logic                       w_new_frame;
  logic [AXIS_W-1:0]          w_tdata;

  psum_vec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VEC_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (psum_valid),
    .i_wr_data   (psum_out),
    .i_rd_en     (w_pop),
    .o_rd_data_c (w_fifo_rd_data),
    .o_full_c    (w_fifo_full),
    .o_empty_c   (w_fifo_empty),
    .o_count     (w_fifo_count),
    .o_wr_drop_c (w_wr_drop)
  );

  assign w_hs        = (r_state == SEND) && m_axis.tready;
  assign w_last_beat = (r_beat_cnt == BEAT_W'(BEATS - 1));
  assign w_last_vec  = (r_vec_cnt == r_frame_len_q - FRAME_LEN_WIDTH'(1));
  assign w_tlast     = (r_state == SEND) && w_last_beat && w_last_vec;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_fifo_empty) w_state_nxt = SEND;
      SEND:    if (w_hs && w_last_beat && w_fifo_empty) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs; a pop on the final beat reloads the shift register with no bubble
  always_comb begin
    w_tvalid    = 1'b0;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    w_new_frame = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop       = !w_fifo_empty;
        w_new_frame = (r_vec_cnt == '0);
      end
      SEND: begin
        w_tvalid    = 1'b1;
        w_shift     = w_hs;
        w_pop       = w_hs && w_last_beat && !w_fifo_empty;
        w_new_frame = w_hs && w_tlast;
      end
      default: ;
    endcase
  end

  // Shift register, beat/vector counters, frame length and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_beat_cnt    <= '0;
      r_vec_cnt     <= '0;
      r_frame_len_q <= FRAME_LEN_WIDTH'(1);
      r_frame_done  <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_frame_done <= w_hs && w_tlast;
      r_overflow   <= r_overflow | w_wr_drop;

      if (w_pop)        r_shift <= w_fifo_rd_data;
      else if (w_shift) r_shift <= r_shift >> BEAT_SH;

      if (w_pop || (w_shift && w_last_beat)) r_beat_cnt <= '0;
      else if (w_shift)                      r_beat_cnt <= r_beat_cnt + BEAT_W'(1);

      if (w_hs && w_last_beat) begin
        if (w_last_vec) r_vec_cnt <= '0;
        else            r_vec_cnt <= r_vec_cnt + FRAME_LEN_WIDTH'(1);
      end

      // A frame length of zero would never raise TLAST, so it is treated as one
      if (w_pop && w_new_frame)
        r_frame_len_q <= (frame_len == '0) ? FRAME_LEN_WIDTH'(1) : frame_len;
    end
  end

  for (genvar g = 0; g < PSUMS_PER_BEAT; g++) begin : g_pack
    assign w_tdata[g*PSUM_PACK_W +: PSUM_PACK_W] =
      sext_psum(PSUM_PACK_W'(r_shift[g*PSUM_W +: PSUM_W]), PSUM_W);
  end

  assign m_axis.tdata     = w_tdata;
  assign m_axis.tvalid    = w_tvalid;
  assign m_axis.tlast     = w_tlast;
  assign psum_almost_full = (w_fifo_count >= CNT_W'(FIFO_DEPTH - 1));
  assign overflow_err     = r_overflow;
  assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_psum_axis_tx.sv
// Directed bench for psum_axis_tx at MAC_NUM=8 (two beats per vector), PSUM_W=5, FIFO_DEPTH=2.
module tb_psum_axis_tx;

  localparam int unsigned MAC_NUM = 8;
  localparam int unsigned PSUM_W  = 5;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned FLW     = 16;
  localparam int unsigned VEC_W   = MAC_NUM * PSUM_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [VEC_W-1:0] psum_out;
  logic             psum_valid;
  logic [FLW-1:0]   frame_len;
  logic             psum_almost_full;
  logic             overflow_err;
  logic             frame_done;

  int checks = 0;
  int errors = 0;

  logic [31:0]      obs_d[$];
  logic             obs_l[$];
  logic [VEC_W-1:0] wr_q[$];
  int               bubbles;
  int               stall_viol;

  psum_axis_tx_if axis_if ();

  psum_axis_tx #(
    .MAC_NUM         (MAC_NUM),
    .PSUM_W          (PSUM_W),
    .FIFO_DEPTH      (DEPTH),
    .FRAME_LEN_WIDTH (FLW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .psum_out         (psum_out),
    .psum_valid       (psum_valid),
    .frame_len        (frame_len),
    .psum_almost_full (psum_almost_full),
    .overflow_err     (overflow_err),
    .frame_done       (frame_done),
    .m_axis           (axis_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VEC_W-1:0] mkvec(input int base);
    logic [VEC_W-1:0] v;
    for (int i = 0; i < MAC_NUM; i++) v[i*PSUM_W +: PSUM_W] = 5'(base + i);
    return v;
  endfunction

  // Reference packing: replicate the sign bit, optionally clamp negatives to zero
  function automatic logic [31:0] exp_beat(input logic [VEC_W-1:0] v, input int b);
    logic [31:0] r;
    logic [4:0]  p;
    logic [7:0]  e;
    for (int k = 0; k < 4; k++) begin
      p = v[(4*b + k)*PSUM_W +: PSUM_W];
      e = {{3{p[4]}}, p};
`ifdef PSUM_TX_RELU_EN
      if (p[4]) e = 8'h00;
`endif
      r[k*8 +: 8] = e;
    end
    return r;
  endfunction

  // Drives queued psum vectors one per cycle and records handshaked beats, bubbles and stall violations
  task automatic record(input int n, input int budget, input bit rand_ready);
    int          cyc;
    bit          stalled;
    logic [31:0] held_d;
    logic        held_l;
    obs_d.delete();
    obs_l.delete();
    bubbles    = 0;
    stall_viol = 0;
    stalled    = 0;
    held_d     = '0;
    held_l     = 1'b0;
    cyc        = 0;
    while (obs_d.size() < n && cyc < budget) begin
      if (wr_q.size() > 0) begin
        psum_valid = 1'b1;
        psum_out   = wr_q.pop_front();
      end else begin
        psum_valid = 1'b0;
      end
      if (rand_ready) axis_if.tready = 1'($urandom_range(0, 1));
      if (stalled && (axis_if.tvalid !== 1'b1 || axis_if.tdata !== held_d || axis_if.tlast !== held_l))
        stall_viol++;
      stalled = 0;
      if (axis_if.tvalid === 1'b1) begin
        if (axis_if.tready === 1'b1) begin
          obs_d.push_back(axis_if.tdata);
          obs_l.push_back(axis_if.tlast);
        end else begin
          stalled = 1;
          held_d  = axis_if.tdata;
          held_l  = axis_if.tlast;
        end
      end else if (obs_d.size() > 0) begin
        bubbles++;
      end
      tick();
      cyc++;
    end
    psum_valid     = 1'b0;
    axis_if.tready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; psum_valid = 1'b0; psum_out = '0; frame_len = 16'd1; axis_if.tready = 1'b0;
    tick(); tick(); tick();
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", axis_if.tvalid); end
    checks++; if (axis_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", axis_if.tlast); end
    checks++; if (axis_if.tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", axis_if.tdata); end
    checks++; if (psum_almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", psum_almost_full); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow_err); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fdone got %b exp 0", frame_done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    axis_if.tready = 1'b1; frame_len = 16'd1;
    psum_valid = 1'b1; psum_out = mkvec(0);
    tick();
    psum_valid = 1'b0;
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL single_latency_early got %b exp 0", axis_if.tvalid); end
    checks++; if (psum_almost_full !== 1'b1) begin errors++; $display("FAIL single_afull got %b exp 1", psum_almost_full); end
    tick();
    checks++; if (axis_if.tvalid !== 1'b1) begin errors++; $display("FAIL single_latency got %b exp 1", axis_if.tvalid); end
    record(2, 20, 0);
    checks++; if (obs_d.size() != 2) begin errors++; $display("FAIL single_count got %0d exp 2", obs_d.size()); end
    if (obs_d.size() == 2) begin
      checks++; if (obs_d[0] !== 32'h03020100) begin errors++; $display("FAIL single_beat0 got %h exp 03020100", obs_d[0]); end
      checks++; if (obs_d[1] !== 32'h07060504) begin errors++; $display("FAIL single_beat1 got %h exp 07060504", obs_d[1]); end
      checks++; if (obs_l[0] !== 1'b0 || obs_l[1] !== 1'b1) begin errors++; $display("FAIL single_tlast got %b%b exp 01", obs_l[0], obs_l[1]); end
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL single_fdone got %b exp 1", frame_done); end
    tick();
    checks++; if (frame_done !== 1'b0 || axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL single_after got fdone=%b tvalid=%b exp 0 0", frame_done, axis_if.tvalid); end
  endtask

  task automatic test_sign_ext();
    logic [VEC_W-1:0] v;
    logic [31:0]      e0;
    logic [31:0]      e1;
    v = {5'h08, 5'h1E, 5'h11, 5'h01, 5'h00, 5'h0F, 5'h10, 5'h1F};
`ifdef PSUM_TX_RELU_EN
    e0 = 32'h000F0000; e1 = 32'h08000001;
`else
    e0 = 32'h000FF0FF; e1 = 32'h08FEF101;
`endif
    frame_len = 16'd1;
    wr_q.push_back(v);
    record(2, 20, 0);
    checks++; if (obs_d.size() != 2) begin errors++; $display("FAIL sext_count got %0d exp 2", obs_d.size()); end
    if (obs_d.size() == 2) begin
      checks++; if (obs_d[0] !== e0) begin errors++; $display("FAIL sext_beat0 got %h exp %h", obs_d[0], e0); end
      checks++; if (obs_d[1] !== e1) begin errors++; $display("FAIL sext_beat1 got %h exp %h", obs_d[1], e1); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [VEC_W-1:0] vecs[3];
    vecs[0] = mkvec(8); vecs[1] = mkvec(16); vecs[2] = mkvec(24);
    frame_len = 16'd3;
    for (int i = 0; i < 3; i++) wr_q.push_back(vecs[i]);
    record(6, 40, 0);
    checks++; if (obs_d.size() != 6) begin errors++; $display("FAIL b2b_count got %0d exp 6", obs_d.size()); end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL b2b_bubbles got %0d exp 0", bubbles); end
    for (int i = 0; i < 6; i++) begin
      if (i < obs_d.size()) begin
        checks++;
        if (obs_d[i] !== exp_beat(vecs[i/2], i%2) || obs_l[i] !== (i == 5)) begin
          errors++;
          $display("FAIL b2b_beat%0d got %h/%b exp %h/%b", i, obs_d[i], obs_l[i], exp_beat(vecs[i/2], i%2), (i == 5));
        end
      end
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_fdone got %b exp 1", frame_done); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [VEC_W-1:0] vecs[2];
    vecs[0] = mkvec(5); vecs[1] = mkvec(19);
    frame_len = 16'd2;
    axis_if.tready = 1'b0;
    wr_q.push_back(vecs[0]); wr_q.push_back(vecs[1]);
    record(4, 200, 1);
    checks++; if (obs_d.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", obs_d.size()); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable got %0d exp 0", stall_viol); end
    for (int i = 0; i < 4; i++) begin
      if (i < obs_d.size()) begin
        checks++;
        if (obs_d[i] !== exp_beat(vecs[i/2], i%2) || obs_l[i] !== (i == 3)) begin
          errors++;
          $display("FAIL bp_beat%0d got %h/%b exp %h/%b", i, obs_d[i], obs_l[i], exp_beat(vecs[i/2], i%2), (i == 3));
        end
      end
    end
    tick(); tick();
  endtask

  task automatic test_overflow();
    logic [VEC_W-1:0] vecs[4];
    for (int i = 0; i < 4; i++) vecs[i] = mkvec(4 + 7*i);
    frame_len = 16'd3;
    axis_if.tready = 1'b0;
    psum_valid = 1'b1; psum_out = vecs[0]; tick();
    checks++; if (psum_almost_full !== 1'b1) begin errors++; $display("FAIL ovf_afull_cnt1 got %b exp 1", psum_almost_full); end
    psum_out = vecs[1]; tick();
    psum_out = vecs[2]; tick();
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow_err); end
    psum_out = vecs[3]; tick();
    psum_valid = 1'b0;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow_err); end
    tick(); tick(); tick();
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_err); end
    axis_if.tready = 1'b1;
    record(6, 40, 0);
    checks++; if (obs_d.size() != 6) begin errors++; $display("FAIL ovf_count got %0d exp 6", obs_d.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < obs_d.size()) begin
        checks++;
        if (obs_d[i] !== exp_beat(vecs[i/2], i%2) || obs_l[i] !== (i == 5)) begin
          errors++;
          $display("FAIL ovf_beat%0d got %h/%b exp %h/%b", i, obs_d[i], obs_l[i], exp_beat(vecs[i/2], i%2), (i == 5));
        end
      end
    end
    tick(); tick();
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL ovf_dropped got tvalid=%b exp 0", axis_if.tvalid); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky2 got %b exp 1", overflow_err); end
  endtask

  task automatic test_reset_mid_send();
    axis_if.tready = 1'b1; frame_len = 16'd2;
    psum_valid = 1'b1; psum_out = mkvec(20); tick();
    psum_out = mkvec(24); tick();
    psum_valid = 1'b0;
    tick(); tick();
    psum_valid = 1'b1; psum_out = mkvec(28); tick();
    psum_valid = 1'b0;
    checks++;
    if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== exp_beat(mkvec(24), 1)) begin
      errors++;
      $display("FAIL rst_pre_beat got %b/%h exp 1/%h", axis_if.tvalid, axis_if.tdata, exp_beat(mkvec(24), 1));
    end
    rst_n = 1'b0; tick();
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid got %b exp 0", axis_if.tvalid); end
    checks++; if (overflow_err !== 1'b0 || psum_almost_full !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got ovf=%b afull=%b exp 0 0", overflow_err, psum_almost_full); end
    rst_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_fifo_empty got tvalid=%b exp 0", axis_if.tvalid); end
    frame_len = 16'd1;
    wr_q.push_back(mkvec(3));
    record(2, 20, 0);
    checks++; if (obs_d.size() != 2) begin errors++; $display("FAIL rst_new_count got %0d exp 2", obs_d.size()); end
    if (obs_d.size() == 2) begin
      checks++; if (obs_d[0] !== 32'h06050403 || obs_l[0] !== 1'b0) begin errors++; $display("FAIL rst_new_beat0 got %h/%b exp 06050403/0", obs_d[0], obs_l[0]); end
      checks++; if (obs_d[1] !== 32'h0A090807 || obs_l[1] !== 1'b1) begin errors++; $display("FAIL rst_new_beat1 got %h/%b exp 0a090807/1", obs_d[1], obs_l[1]); end
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL rst_new_fdone got %b exp 1", frame_done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_sign_ext();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
